// File: rtl/muldiv_seq_if.sv
// Pipeline-side interface of the multiply/divide sequencer.
// The master drives requests from execute; the slave returns handshake and HI/LO.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       fncode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             hilo_read;
    logic             accept;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, fncode, op_a, op_b, flush, hilo_read,
        input  accept, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, fncode, op_a, op_b, flush, hilo_read,
        output accept, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shift-add or restoring-subtract step per cycle on a shared {acc,q} datapath.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    muldiv_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request; MTHI/MTLO are served here
    // RUN   | one mul/div step per cycle while count runs down to 0
    // FIXUP | sign correction of the magnitude result, HI/LO written on exit
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;
    logic             is_div;
    logic             div0;
    logic             done_r;

    logic             op_md;
    logic             op_mt;
    logic             op_div;
    logic             op_sgn;
    logic             accept;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   sub_diff;
    logic               sub_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    always_comb begin
        op_md  = 1'b0;
        op_mt  = 1'b0;
        op_div = 1'b0;
        op_sgn = 1'b0;
        case (bus.fncode)
            FN_MULT:  begin op_md = 1'b1; op_sgn = 1'b1; end
            FN_MULTU: begin op_md = 1'b1; end
            FN_DIV:   begin op_md = 1'b1; op_div = 1'b1; op_sgn = 1'b1; end
            FN_DIVU:  begin op_md = 1'b1; op_div = 1'b1; end
            FN_MTHI,
            FN_MTLO:  begin op_mt = 1'b1; end
            default:  ;
        endcase
    end

    // flush in IDLE suppresses any request presented in the same cycle
    assign accept = bus.start && (state == IDLE) && (op_md || op_mt) && !bus.flush;

    // magnitudes in WIDTH-bit unsigned form, so the most negative value maps to itself
    assign sa    = op_sgn & bus.op_a[WIDTH-1];
    assign sb    = op_sgn & bus.op_b[WIDTH-1];
    assign abs_a = sa ? -bus.op_a : bus.op_a;
    assign abs_b = sb ? -bus.op_b : bus.op_b;

    assign add_sum  = {1'b0, acc} + (q[0] ? {1'b0, dvsr} : '0);
    assign rem_sh   = {acc, q[WIDTH-1]};
    assign sub_ok   = (rem_sh >= {1'b0, dvsr});
    assign sub_diff = rem_sh[WIDTH-1:0] - dvsr;

    assign prod_fix = neg_q ? -{acc, q} : {acc, q};

    always_comb begin
        hi_next = prod_fix[2*WIDTH-1:WIDTH];
        lo_next = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                hi_next = a_raw;
                lo_next = '1;
            end else begin
                hi_next = neg_r ? -acc : acc;
                lo_next = neg_q ? -q : q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            q      <= '0;
            dvsr   <= '0;
            a_raw  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_mt) begin
                            if (bus.fncode == FN_MTHI) hi_r <= bus.op_a;
                            else                       lo_r <= bus.op_a;
                        end else begin
                            state  <= RUN;
                            acc    <= '0;
                            q      <= op_div ? abs_a : abs_b;
                            dvsr   <= op_div ? abs_b : abs_a;
                            a_raw  <= bus.op_a;
                            neg_q  <= sa ^ sb;
                            neg_r  <= sa;
                            is_div <= op_div;
                            div0   <= op_div && (bus.op_b == '0);
                            count  <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= sub_ok ? sub_diff : rem_sh[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], sub_ok};
                        end else begin
                            acc <= add_sum[WIDTH:1];
                            q   <= {add_sum[0], q[WIDTH-1:1]};
                        end
                        count <= count - CW'(1);
                        if (count == '0) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        hi_r   <= hi_next;
                        lo_r   <= lo_next;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.accept = accept;
    assign bus.busy   = (state == RUN) || (state == FIXUP);
    assign bus.stall  = bus.hilo_read && bus.busy;
    assign bus.done   = done_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;
endmodule
